unidade_proximo_pc: RTL and testbench
=====================================

Name: unidade_proximo_pc

Overview:
- Parametrised program-counter unit for the MIPS core. It is the next generation of the single-mode PC calculator.
- Owns the PC register and selects the next PC among the following sources:
  - sequential fetch
  - conditional branch (beq/bne)
  - absolute jump (j/jal)
  - register jump (jr)
  - exception vector
  - exception return
- Adds the following behaviour:
  - stall hold
  - buffering of redirects that arrive during a stall
  - EPC capture
  - a one-cycle flush pulse for the fetch/decode stages

Parameters:
- LARGURA, 32, PC/data width in bits (≥ 28).
- END_BYTE, 0: 0 = word-addressed memory (increment 1, offsets unshifted); 1 = byte-addressed (increment 4, offsets shifted left by 2).
- PC_RESET, 0, PC value loaded on reset.
- VETOR_EXC, 32'h00000080, exception handler address (truncated to LARGURA).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold PC (pipeline stall).
- branch  input  1  current instruction is a conditional branch.
- branch_ne  input  1  1 = bne semantics, 0 = beq.
- zero  input  1  ALU zero flag.
- jump  input  1  absolute jump (j/jal).
- jump_reg  input  1  register jump (jr).
- exc  input  1  exception request.
- eret  input  1  exception return.
- imediato  input  LARGURA  sign-extended branch offset.
- alvo_jump  input  26  jump target field.
- reg_alvo  input  LARGURA  register value for jr.
- pc  output  LARGURA  current PC (registered).
- pc_mais  output  LARGURA  pc + INC (combinational), used for link.
- epc  output  LARGURA  saved exception PC (registered).
- flush  output  1  one-cycle pulse: a non-sequential PC was loaded on the last edge.
- redir_pend  output  1  a redirect is buffered awaiting stall release.

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-stall or with a pending redirect):
  - pc=PC_RESET, epc=0, flush=0, redir_pend=0.
  - The pending target is cleared.
- Constants:
  - INC = END_BYTE ? 4 : 1
  - SH = END_BYTE ? 2 : 0
  - All arithmetic is modulo 2^LARGURA; wrap-around is silent.
- Candidate targets:
  - seq = pc + INC
  - br = pc + INC + (imediato << SH)
  - jmp = {pc_mais[LARGURA-1:26+SH], alvo_jump, SH zeros}
  - jr = reg_alvo
- taken = branch & (zero XOR branch_ne).
- Request priority (highest first): exc > eret > jump_reg > jump > taken.
  - The winner is the request target; with none active, the target is seq.
- exc handling:
  - Accepted regardless of stall.
  - On the edge: epc <= pc, pc <= VETOR_EXC, flush <= 1, pending cleared.
- Edge with stall=0 and no pending redirect:
  - pc <= winner target.
  - flush <= 1 if the winner was a redirect (eret/jr/j/taken), else 0.
- Edge with stall=0 and pending redirect:
  - pc <= pending target, flush <= 1, pending cleared.
  - Any simultaneous non-exc request on this cycle is ignored (its instruction is being flushed).
- Edge with stall=1, no exc:
  - pc holds, flush <= 0.
  - If a redirect request is active and nothing is pending: latch its target and set redir_pend.
  - If a redirect is already pending: the pending target is kept; later requests are ignored.
- eret target is the epc value at the request edge.
- Latency:
  - A request sampled at edge N appears on pc after edge N; flush is high for cycle N+1 only.
  - A buffered redirect appears on pc at the first edge with stall=0.
- Simultaneous eret and exc: exc wins; epc <= current pc.

Test Plan:
- Reset/sequential: rst_n low then high, END_BYTE=0, no requests, 3 clocks → pc 0,1,2,3; flush=0 throughout.
- beq/bne: END_BYTE=1, pc=0x100, imediato=-2, branch=1, zero=1, branch_ne=0 → pc=0xFC, flush=1 one cycle. Repeat with branch_ne=1 → pc=0x104, flush=0.
- Jump/jr priority: pc=0x40000010 (END_BYTE=1), jump=1, alvo_jump=0x10, jump_reg=1, reg_alvo=0x2000 → pc=0x2000. Then jump alone → pc=0x40000040.
- Stall buffering: stall=1 for 3 cycles, jump_reg (reg_alvo=0x500) in cycle 1 and jump in cycle 2 → pc held, redir_pend=1 from cycle 2. Release stall → pc=0x500, flush=1, redir_pend=0.
- Exception/eret: pc=0x1234, exc=1 during stall=1 → pc=0x80, epc=0x1234, flush=1. Later eret=1 → pc=0x1234. Simultaneous exc+eret → exc wins.
- Wrap/reset mid-op: pc=0xFFFFFFFF (END_BYTE=0) → next pc=0. Assert rst_n low asynchronously with redir_pend=1 → pc=PC_RESET immediately, redir_pend=0.

Source files
------------

// File: rtl/unidade_proximo_pc.sv
// Program-counter unit: owns the PC and picks the next PC from sequential fetch,
// branch, jump, jr, exception vector and eret. Redirects that arrive during a stall are held until release.
module unidade_proximo_pc #(
  parameter int                 LARGURA   = 32,
  parameter int                 END_BYTE  = 0,
  parameter logic [LARGURA-1:0] PC_RESET  = '0,
  parameter logic [31:0]        VETOR_EXC = 32'h00000080
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               branch,
  input  logic               branch_ne,
  input  logic               zero,
  input  logic               jump,
  input  logic               jump_reg,
  input  logic               exc,
  input  logic               eret,
  input  logic [LARGURA-1:0] imediato,
  input  logic [25:0]        alvo_jump,
  input  logic [LARGURA-1:0] reg_alvo,
  output logic [LARGURA-1:0] pc,
  output logic [LARGURA-1:0] pc_mais,
  output logic [LARGURA-1:0] epc,
  output logic               flush,
  output logic               redir_pend
);

  localparam int                 SH    = (END_BYTE != 0) ? 2 : 0;
  localparam logic [LARGURA-1:0] INC   = LARGURA'((END_BYTE != 0) ? 4 : 1);
  localparam logic [LARGURA-1:0] VETOR = LARGURA'(VETOR_EXC);

  // Bits above the jump field come from pc_mais; the field plus SH zero bits fill the rest.
  localparam logic [LARGURA-1:0] MASCARA_ALTO =
    ~((LARGURA'(1) << (26 + SH)) - LARGURA'(1));

  logic [LARGURA-1:0] alvo_br;
  logic [LARGURA-1:0] alvo_j;
  logic [LARGURA-1:0] alvo_req;
  logic [LARGURA-1:0] alvo_pend;
  logic               taken;
  logic               redir;

  assign pc_mais = pc + INC;
  assign alvo_br = pc_mais + (imediato << SH);
  assign alvo_j  = (pc_mais & MASCARA_ALTO) | (LARGURA'(alvo_jump) << SH);
  assign taken   = branch & (zero ^ branch_ne);
  assign redir   = eret | jump_reg | jump | taken;

  always_comb begin
    alvo_req = pc_mais;
    if (eret)          alvo_req = epc;
    else if (jump_reg) alvo_req = reg_alvo;
    else if (jump)     alvo_req = alvo_j;
    else if (taken)    alvo_req = alvo_br;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= PC_RESET;
      epc        <= '0;
      flush      <= 1'b0;
      redir_pend <= 1'b0;
      alvo_pend  <= '0;
    end else if (exc) begin
      epc        <= pc;
      pc         <= VETOR;
      flush      <= 1'b1;
      redir_pend <= 1'b0;
      alvo_pend  <= '0;
    end else if (!stall) begin
      // A buffered redirect wins; the instruction issuing now is on the flushed path.
      if (redir_pend) begin
        pc         <= alvo_pend;
        flush      <= 1'b1;
        redir_pend <= 1'b0;
      end else begin
        pc    <= alvo_req;
        flush <= redir;
      end
    end else begin
      flush <= 1'b0;
      if (redir && !redir_pend) begin
        alvo_pend  <= alvo_req;
        redir_pend <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_unidade_proximo_pc.sv
// Bench for unidade_proximo_pc: a byte-addressed and a word-addressed instance share stimulus;
// expected states are queued as each row is driven and popped after the edge.
module tb_unidade_proximo_pc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, branch, branch_ne, zero, jump, jump_reg, exc, eret;
  logic [31:0] imediato, reg_alvo;
  logic [25:0] alvo_jump;

  logic [31:0] b_pc, b_pc_mais, b_epc, w_pc, w_pc_mais, w_epc;
  logic        b_flush, b_pend, w_flush, w_pend;

  localparam logic [7:0] ST = 8'h80, BR = 8'h40, NE = 8'h20, Z = 8'h10,
                         J  = 8'h08, JR = 8'h04, EX = 8'h02, ER = 8'h01;

  typedef struct {
    logic [7:0]  f;
    logic [31:0] imm;
    logic [25:0] aj;
    logic [31:0] ra;
  } stim_t;

  typedef struct {
    logic [31:0] pc;
    logic        flush;
    logic [31:0] epc;
    logic        pend;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  unidade_proximo_pc #(.LARGURA(32), .END_BYTE(1), .PC_RESET(32'h200), .VETOR_EXC(32'h80)) u_b (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .branch_ne(branch_ne),
    .zero(zero), .jump(jump), .jump_reg(jump_reg), .exc(exc), .eret(eret),
    .imediato(imediato), .alvo_jump(alvo_jump), .reg_alvo(reg_alvo),
    .pc(b_pc), .pc_mais(b_pc_mais), .epc(b_epc), .flush(b_flush), .redir_pend(b_pend)
  );

  unidade_proximo_pc #(.LARGURA(32), .END_BYTE(0), .PC_RESET(32'h0), .VETOR_EXC(32'h80)) u_w (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .branch_ne(branch_ne),
    .zero(zero), .jump(jump), .jump_reg(jump_reg), .exc(exc), .eret(eret),
    .imediato(imediato), .alvo_jump(alvo_jump), .reg_alvo(reg_alvo),
    .pc(w_pc), .pc_mais(w_pc_mais), .epc(w_epc), .flush(w_flush), .redir_pend(w_pend)
  );

  task automatic apply(input stim_t s);
    {stall, branch, branch_ne, zero, jump, jump_reg, exc, eret} = s.f;
    imediato  = s.imm;
    alvo_jump = s.aj;
    reg_alvo  = s.ra;
  endtask

  task automatic test_reset;
    stim_t s[$];
    exp_t  x[$];
    exp_t  e;
    rst_n = 1'b0;
    apply('{8'h00, 32'h0, 26'h0, 32'h0});
    #12;
    n_chk++;
    if ({w_pc, w_flush, w_epc, w_pend} !== {32'h0, 1'b0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_w: got pc=%h flush=%b epc=%h pend=%b, want pc=0 flush=0 epc=0 pend=0",
               w_pc, w_flush, w_epc, w_pend);
    end
    n_chk++;
    if ({b_pc, b_flush, b_epc, b_pend} !== {32'h200, 1'b0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_b: got pc=%h flush=%b epc=%h pend=%b, want pc=200 flush=0 epc=0 pend=0",
               b_pc, b_flush, b_epc, b_pend);
    end
    n_chk++;
    if ({w_pc_mais, b_pc_mais} !== {32'h1, 32'h204}) begin
      n_fail++;
      $display("FAIL reset_pc_mais: got w=%h b=%h, want w=1 b=204", w_pc_mais, b_pc_mais);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      s.push_back('{8'h00, 32'h0, 26'h0, 32'h0});
      x.push_back('{32'(i), 1'b0, 32'h0, 1'b0});
    end
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back(x[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if ({w_pc, w_flush, w_epc, w_pend} !== {e.pc, e.flush, e.epc, e.pend}) begin
        n_fail++;
        $display("FAIL seq[%0d]: got pc=%h flush=%b epc=%h pend=%b, want pc=%h flush=%b epc=%h pend=%b",
                 i, w_pc, w_flush, w_epc, w_pend, e.pc, e.flush, e.epc, e.pend);
      end
    end
  endtask

  task automatic test_branch;
    stim_t s[$];
    exp_t  x[$];
    exp_t  e;
    s.push_back('{JR,        32'h0,        26'h0, 32'h100}); x.push_back('{32'h100, 1'b1, 32'h0, 1'b0});
    s.push_back('{BR|Z,      32'hFFFFFFFE, 26'h0, 32'h0});   x.push_back('{32'h0FC, 1'b1, 32'h0, 1'b0});
    s.push_back('{8'h00,     32'h0,        26'h0, 32'h0});   x.push_back('{32'h100, 1'b0, 32'h0, 1'b0});
    s.push_back('{BR|NE|Z,   32'hFFFFFFFE, 26'h0, 32'h0});   x.push_back('{32'h104, 1'b0, 32'h0, 1'b0});
    s.push_back('{BR|NE,     32'hFFFFFFFE, 26'h0, 32'h0});   x.push_back('{32'h100, 1'b1, 32'h0, 1'b0});
    s.push_back('{BR,        32'h3,        26'h0, 32'h0});   x.push_back('{32'h104, 1'b0, 32'h0, 1'b0});
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back(x[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if ({b_pc, b_flush, b_epc, b_pend} !== {e.pc, e.flush, e.epc, e.pend}) begin
        n_fail++;
        $display("FAIL branch[%0d]: got pc=%h flush=%b epc=%h pend=%b, want pc=%h flush=%b epc=%h pend=%b",
                 i, b_pc, b_flush, b_epc, b_pend, e.pc, e.flush, e.epc, e.pend);
      end
    end
  endtask

  task automatic test_jump_priority;
    stim_t s[$];
    exp_t  x[$];
    exp_t  e;
    s.push_back('{JR,     32'h0, 26'h0,       32'h40000010}); x.push_back('{32'h40000010, 1'b1, 32'h0, 1'b0});
    s.push_back('{J|JR,   32'h0, 26'h10,      32'h2000});     x.push_back('{32'h00002000, 1'b1, 32'h0, 1'b0});
    s.push_back('{JR,     32'h0, 26'h0,       32'h40000010}); x.push_back('{32'h40000010, 1'b1, 32'h0, 1'b0});
    s.push_back('{J,      32'h0, 26'h10,      32'h0});        x.push_back('{32'h40000040, 1'b1, 32'h0, 1'b0});
    s.push_back('{J|BR|Z, 32'h8, 26'h3FFFFFF, 32'h0});        x.push_back('{32'h4FFFFFFC, 1'b1, 32'h0, 1'b0});
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back(x[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if ({b_pc, b_flush, b_epc, b_pend} !== {e.pc, e.flush, e.epc, e.pend}) begin
        n_fail++;
        $display("FAIL jump[%0d]: got pc=%h flush=%b epc=%h pend=%b, want pc=%h flush=%b epc=%h pend=%b",
                 i, b_pc, b_flush, b_epc, b_pend, e.pc, e.flush, e.epc, e.pend);
      end
    end
    n_chk++;
    if (b_pc_mais !== 32'h50000000) begin
      n_fail++;
      $display("FAIL jump_pc_mais: got %h, want 50000000", b_pc_mais);
    end
  endtask

  task automatic test_stall_buffer;
    stim_t s[$];
    exp_t  x[$];
    exp_t  e;
    s.push_back('{JR,      32'h0, 26'h0,  32'h1000}); x.push_back('{32'h1000, 1'b1, 32'h0, 1'b0});
    s.push_back('{ST,      32'h0, 26'h0,  32'h0});    x.push_back('{32'h1000, 1'b0, 32'h0, 1'b0});
    s.push_back('{ST|JR,   32'h0, 26'h0,  32'h500});  x.push_back('{32'h1000, 1'b0, 32'h0, 1'b1});
    s.push_back('{ST|J,    32'h0, 26'h20, 32'h0});    x.push_back('{32'h1000, 1'b0, 32'h0, 1'b1});
    s.push_back('{ST,      32'h0, 26'h0,  32'h0});    x.push_back('{32'h1000, 1'b0, 32'h0, 1'b1});
    s.push_back('{8'h00,   32'h0, 26'h0,  32'h0});    x.push_back('{32'h0500, 1'b1, 32'h0, 1'b0});
    s.push_back('{8'h00,   32'h0, 26'h0,  32'h0});    x.push_back('{32'h0504, 1'b0, 32'h0, 1'b0});
    s.push_back('{ST|BR|Z, 32'h4, 26'h0,  32'h0});    x.push_back('{32'h0504, 1'b0, 32'h0, 1'b1});
    s.push_back('{JR,      32'h0, 26'h0,  32'h9999}); x.push_back('{32'h0518, 1'b1, 32'h0, 1'b0});
    s.push_back('{8'h00,   32'h0, 26'h0,  32'h0});    x.push_back('{32'h051C, 1'b0, 32'h0, 1'b0});
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back(x[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if ({b_pc, b_flush, b_epc, b_pend} !== {e.pc, e.flush, e.epc, e.pend}) begin
        n_fail++;
        $display("FAIL stall[%0d]: got pc=%h flush=%b epc=%h pend=%b, want pc=%h flush=%b epc=%h pend=%b",
                 i, b_pc, b_flush, b_epc, b_pend, e.pc, e.flush, e.epc, e.pend);
      end
    end
  endtask

  task automatic test_exc_eret;
    stim_t s[$];
    exp_t  x[$];
    exp_t  e;
    s.push_back('{JR,    32'h0, 26'h0, 32'h1234}); x.push_back('{32'h1234, 1'b1, 32'h0,    1'b0});
    s.push_back('{ST|EX, 32'h0, 26'h0, 32'h0});    x.push_back('{32'h0080, 1'b1, 32'h1234, 1'b0});
    s.push_back('{8'h00, 32'h0, 26'h0, 32'h0});    x.push_back('{32'h0084, 1'b0, 32'h1234, 1'b0});
    s.push_back('{ER,    32'h0, 26'h0, 32'h0});    x.push_back('{32'h1234, 1'b1, 32'h1234, 1'b0});
    s.push_back('{8'h00, 32'h0, 26'h0, 32'h0});    x.push_back('{32'h1238, 1'b0, 32'h1234, 1'b0});
    s.push_back('{EX|ER, 32'h0, 26'h0, 32'h0});    x.push_back('{32'h0080, 1'b1, 32'h1238, 1'b0});
    s.push_back('{ER|JR, 32'h0, 26'h0, 32'h7777}); x.push_back('{32'h1238, 1'b1, 32'h1238, 1'b0});
    s.push_back('{ST|JR, 32'h0, 26'h0, 32'h600});  x.push_back('{32'h1238, 1'b0, 32'h1238, 1'b1});
    s.push_back('{ST|EX, 32'h0, 26'h0, 32'h0});    x.push_back('{32'h0080, 1'b1, 32'h1238, 1'b0});
    s.push_back('{8'h00, 32'h0, 26'h0, 32'h0});    x.push_back('{32'h0084, 1'b0, 32'h1238, 1'b0});
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back(x[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if ({b_pc, b_flush, b_epc, b_pend} !== {e.pc, e.flush, e.epc, e.pend}) begin
        n_fail++;
        $display("FAIL exc[%0d]: got pc=%h flush=%b epc=%h pend=%b, want pc=%h flush=%b epc=%h pend=%b",
                 i, b_pc, b_flush, b_epc, b_pend, e.pc, e.flush, e.epc, e.pend);
      end
    end
  endtask

  task automatic test_wrap_reset;
    stim_t s[$];
    exp_t  x[$];
    exp_t  e;
    // Word-addressed instance: epc still holds its last exception PC from the previous scenario.
    s.push_back('{JR,    32'h0, 26'h0, 32'hFFFFFFFF}); x.push_back('{32'hFFFFFFFF, 1'b1, 32'h1235, 1'b0});
    s.push_back('{8'h00, 32'h0, 26'h0, 32'h0});        x.push_back('{32'h00000000, 1'b0, 32'h1235, 1'b0});
    s.push_back('{8'h00, 32'h0, 26'h0, 32'h0});        x.push_back('{32'h00000001, 1'b0, 32'h1235, 1'b0});
    s.push_back('{ST|JR, 32'h0, 26'h0, 32'h10});       x.push_back('{32'h00000001, 1'b0, 32'h1235, 1'b1});
    foreach (s[i]) begin
      apply(s[i]);
      sb.push_back(x[i]);
      @(posedge clk); #1;
      e = sb.pop_front();
      n_chk++;
      if ({w_pc, w_flush, w_epc, w_pend} !== {e.pc, e.flush, e.epc, e.pend}) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got pc=%h flush=%b epc=%h pend=%b, want pc=%h flush=%b epc=%h pend=%b",
                 i, w_pc, w_flush, w_epc, w_pend, e.pc, e.flush, e.epc, e.pend);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({w_pc, w_flush, w_epc, w_pend} !== {32'h0, 1'b0, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_w: got pc=%h flush=%b epc=%h pend=%b, want pc=0 flush=0 epc=0 pend=0",
               w_pc, w_flush, w_epc, w_pend);
    end
    n_chk++;
    if ({b_pc, b_epc, b_pend} !== {32'h200, 32'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset_b: got pc=%h epc=%h pend=%b, want pc=200 epc=0 pend=0",
               b_pc, b_epc, b_pend);
    end
    @(negedge clk);
    rst_n = 1'b1;
    apply('{8'h00, 32'h0, 26'h0, 32'h0});
    sb.push_back('{32'h1, 1'b0, 32'h0, 1'b0});
    @(posedge clk); #1;
    e = sb.pop_front();
    n_chk++;
    if ({w_pc, w_flush, w_epc, w_pend} !== {e.pc, e.flush, e.epc, e.pend}) begin
      n_fail++;
      $display("FAIL post_reset: got pc=%h flush=%b epc=%h pend=%b, want pc=%h flush=%b epc=%h pend=%b",
               w_pc, w_flush, w_epc, w_pend, e.pc, e.flush, e.epc, e.pend);
    end
    n_chk++;
    if (b_pc !== 32'h204) begin
      n_fail++;
      $display("FAIL post_reset_b: got pc=%h, want 204", b_pc);
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump_priority();
    test_stall_buffer();
    test_exc_eret();
    test_wrap_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
